// File: rtl/rab_slice_pkg.sv
// Shared types for the RAB slice lookup: config word layout, per-slice config
// struct with unpack helper, and the registered lookup result.
package rab_slice_pkg;

  localparam int CFG_MIN    = 0;
  localparam int CFG_MAX    = 1;
  localparam int CFG_OFFSET = 2;
  localparam int CFG_FLAGS  = 3;

  localparam int FLAG_EN     = 0;
  localparam int FLAG_REN    = 1;
  localparam int FLAG_WEN    = 2;
  localparam int FLAG_MASTER = 3;

  localparam int MAX_IDX_W  = 6;
  localparam int MAX_ADDR_W = 64;

  typedef struct packed {
    logic [63:0] min;
    logic [63:0] max;
    logic [63:0] offset;
    logic [59:0] rsvd;
    logic        master_sel;
    logic        wen;
    logic        ren;
    logic        en;
  } slice_cfg_t;

  // Sized for the largest legal build; the top truncates to its parameters.
  typedef struct packed {
    logic                  hit;
    logic                  multi;
    logic                  prot;
    logic                  master_sel;
    logic [MAX_IDX_W-1:0]  idx;
    logic [MAX_ADDR_W-1:0] addr;
  } lookup_result_t;

  function automatic slice_cfg_t unpack_slice(input logic [3:0][63:0] w);
    slice_cfg_t c;
    c.min        = w[CFG_MIN];
    c.max        = w[CFG_MAX];
    c.offset     = w[CFG_OFFSET];
    c.rsvd       = w[CFG_FLAGS][63:4];
    c.master_sel = w[CFG_FLAGS][FLAG_MASTER];
    c.wen        = w[CFG_FLAGS][FLAG_WEN];
    c.ren        = w[CFG_FLAGS][FLAG_REN];
    c.en         = w[CFG_FLAGS][FLAG_EN];
    return c;
  endfunction

endpackage

// File: rtl/rab_slice_match.sv
// One slice: burst range containment, read/write permission and translation.
// Purely combinational; the top registers the reduced result.
module rab_slice_match
  import rab_slice_pkg::*;
#(
  parameter int AW_VIRT = 32,
  parameter int AW_PHYS = 40
) (
  input  slice_cfg_t         cfg_i,
  input  logic               rw_i,
  input  logic [AW_VIRT-1:0] min_i,
  input  logic [AW_VIRT-1:0] max_i,
  output logic               match_o,
  output logic               hit_o,
  output logic               prot_o,
  output logic [AW_PHYS-1:0] addr_o
);

  logic [AW_VIRT-1:0] cfg_min;
  logic [AW_VIRT-1:0] cfg_max;
  logic [AW_VIRT-1:0] delta;
  logic               permit;
  logic               unused_cfg;

  assign cfg_min = cfg_i.min[AW_VIRT-1:0];
  assign cfg_max = cfg_i.max[AW_VIRT-1:0];
  assign delta   = min_i - cfg_min;

  assign match_o = cfg_i.en && (min_i >= cfg_min) && (max_i <= cfg_max);
  assign permit  = rw_i ? cfg_i.wen : cfg_i.ren;
  assign hit_o   = match_o && permit;
  assign prot_o  = match_o && !permit;

  // Wraps modulo 2^AW_PHYS by construction of the result width.
  assign addr_o = AW_PHYS'(delta) + cfg_i.offset[AW_PHYS-1:0];

  assign unused_cfg = ^{cfg_i.min, cfg_i.max, cfg_i.offset, cfg_i.rsvd, cfg_i.master_sel};

endmodule

// File: rtl/rab_slice_lookup.sv
// Two-stage elastic RAB slice lookup, one result per request, 2-cycle latency.
// Optional statistics counters enabled by defining RAB_LOOKUP_STATS_EN.
module rab_slice_lookup
  import rab_slice_pkg::*;
#(
  parameter int N_SLICES        = 16,
  parameter int ADDR_WIDTH_VIRT = 32,
  parameter int ADDR_WIDTH_PHYS = 40,
  parameter int ID_WIDTH        = 4,
  parameter int CNT_WIDTH       = 32,
  localparam int IDX_W          = (N_SLICES > 1) ? $clog2(N_SLICES) : 1
) (
  input  logic                            Clk_CI,
  input  logic                            Rst_RBI,
  input  logic [4*N_SLICES-1:0][63:0]     CfgRegs_DI,
  input  logic                            ReqValid_SI,
  output logic                            ReqReady_SO,
  input  logic                            ReqRw_DI,
  input  logic [ADDR_WIDTH_VIRT-1:0]      ReqAddrMin_DI,
  input  logic [ADDR_WIDTH_VIRT-1:0]      ReqAddrMax_DI,
  input  logic [ID_WIDTH-1:0]             ReqId_DI,
  output logic                            RespValid_SO,
  input  logic                            RespReady_SI,
  output logic [ID_WIDTH-1:0]             RespId_DO,
  output logic                            RespHit_SO,
  output logic                            RespMulti_SO,
  output logic                            RespProt_SO,
  output logic [IDX_W-1:0]                RespIdx_DO,
  output logic [ADDR_WIDTH_PHYS-1:0]      RespAddr_DO,
  output logic                            RespMasterSel_SO
`ifdef RAB_LOOKUP_STATS_EN
  ,
  input  logic                            StatClr_SI,
  output logic [CNT_WIDTH-1:0]            StatHit_DO,
  output logic [CNT_WIDTH-1:0]            StatMiss_DO,
  output logic [CNT_WIDTH-1:0]            StatMulti_DO,
  output logic [CNT_WIDTH-1:0]            StatProt_DO
`endif
);

  logic                       s1_vld_q, s1_vld_d, s1_rdy;
  logic                       s1_rw_q;
  logic [ADDR_WIDTH_VIRT-1:0] s1_min_q, s1_max_q;
  logic [ID_WIDTH-1:0]        s1_id_q;
  logic                       s2_vld_q, s2_vld_d, s2_rdy;
  logic [ID_WIDTH-1:0]        s2_id_q;
  lookup_result_t             s2_res_q, res_d;

  slice_cfg_t                 cfg [N_SLICES];
  logic [N_SLICES-1:0]        match_vec, hit_vec, prot_vec;
  logic [ADDR_WIDTH_PHYS-1:0] addr_arr [N_SLICES];
  logic                       any_hit, multi;
  logic [IDX_W-1:0]           low_idx;
  logic                       unused_bits;

  assign s2_rdy      = !s2_vld_q || RespReady_SI;
  assign s1_rdy      = !s1_vld_q || s2_rdy;
  assign ReqReady_SO = s1_rdy;
  assign s1_vld_d    = s1_rdy ? ReqValid_SI : s1_vld_q;
  assign s2_vld_d    = s2_rdy ? s1_vld_q : s2_vld_q;

  for (genvar g = 0; g < N_SLICES; g++) begin : g_slice
    assign cfg[g] = unpack_slice(CfgRegs_DI[4*g +: 4]);
    rab_slice_match #(
      .AW_VIRT (ADDR_WIDTH_VIRT),
      .AW_PHYS (ADDR_WIDTH_PHYS)
    ) u_match (
      .cfg_i   (cfg[g]),
      .rw_i    (s1_rw_q),
      .min_i   (s1_min_q),
      .max_i   (s1_max_q),
      .match_o (match_vec[g]),
      .hit_o   (hit_vec[g]),
      .prot_o  (prot_vec[g]),
      .addr_o  (addr_arr[g])
    );
  end

  always_comb begin
    any_hit = |hit_vec;
    // Clearing the lowest set bit leaves something only if two or more hit.
    multi   = |(hit_vec & (hit_vec - N_SLICES'(1)));
    low_idx = '0;
    for (int i = N_SLICES - 1; i >= 0; i--) begin
      if (hit_vec[i]) low_idx = IDX_W'(i);
    end
    res_d       = '0;
    res_d.multi = multi;
    if (any_hit) res_d.idx = MAX_IDX_W'(low_idx);
    if (any_hit && !multi) begin
      res_d.hit        = 1'b1;
      res_d.addr       = MAX_ADDR_W'(addr_arr[low_idx]);
      res_d.master_sel = cfg[low_idx].master_sel;
    end
    if (!any_hit) res_d.prot = |prot_vec;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      s1_vld_q <= 1'b0;
      s1_rw_q  <= 1'b0;
      s1_min_q <= '0;
      s1_max_q <= '0;
      s1_id_q  <= '0;
      s2_vld_q <= 1'b0;
      s2_id_q  <= '0;
      s2_res_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      if (s1_rdy && ReqValid_SI) begin
        s1_rw_q  <= ReqRw_DI;
        s1_min_q <= ReqAddrMin_DI;
        s1_max_q <= ReqAddrMax_DI;
        s1_id_q  <= ReqId_DI;
      end
      if (s2_rdy && s1_vld_q) begin
        s2_id_q  <= s1_id_q;
        s2_res_q <= res_d;
      end
    end
  end

  assign RespValid_SO     = s2_vld_q;
  assign RespId_DO        = s2_id_q;
  assign RespHit_SO       = s2_res_q.hit;
  assign RespMulti_SO     = s2_res_q.multi;
  assign RespProt_SO      = s2_res_q.prot;
  assign RespIdx_DO       = s2_res_q.idx[IDX_W-1:0];
  assign RespAddr_DO      = s2_res_q.addr[ADDR_WIDTH_PHYS-1:0];
  assign RespMasterSel_SO = s2_res_q.master_sel;

  assign unused_bits = ^{match_vec, s2_res_q};

`ifdef RAB_LOOKUP_STATS_EN
  logic                 resp_hs;
  logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q, multi_cnt_q, prot_cnt_q;
  logic [CNT_WIDTH-1:0] hit_cnt_d, miss_cnt_d, multi_cnt_d, prot_cnt_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic inc);
    return (inc && (c != '1)) ? c + CNT_WIDTH'(1) : c;
  endfunction

  assign resp_hs = s2_vld_q && RespReady_SI;

  always_comb begin
    hit_cnt_d   = sat_inc(hit_cnt_q,   resp_hs && s2_res_q.hit);
    miss_cnt_d  = sat_inc(miss_cnt_q,  resp_hs && !s2_res_q.hit && !s2_res_q.multi);
    multi_cnt_d = sat_inc(multi_cnt_q, resp_hs && s2_res_q.multi);
    prot_cnt_d  = sat_inc(prot_cnt_q,  resp_hs && s2_res_q.prot);
    if (StatClr_SI) begin
      hit_cnt_d   = '0;
      miss_cnt_d  = '0;
      multi_cnt_d = '0;
      prot_cnt_d  = '0;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      multi_cnt_q <= '0;
      prot_cnt_q  <= '0;
    end else begin
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      multi_cnt_q <= multi_cnt_d;
      prot_cnt_q  <= prot_cnt_d;
    end
  end

  assign StatHit_DO   = hit_cnt_q;
  assign StatMiss_DO  = miss_cnt_q;
  assign StatMulti_DO = multi_cnt_q;
  assign StatProt_DO  = prot_cnt_q;
`else
  localparam int unused_cnt_w = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_rab_slice_lookup.sv
// Directed bench for rab_slice_lookup: hit/prot/miss/multi, offset wrap,
// elastic back-to-back flow, mid-stream reset and optional statistics.
module tb_rab_slice_lookup;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [63:0][63:0]  cfg_regs;
  logic               req_vld, req_rdy, req_rw;
  logic [31:0]        req_min, req_max;
  logic [3:0]         req_id;
  logic               resp_vld, resp_rdy;
  logic [3:0]         resp_id;
  logic               resp_hit, resp_multi, resp_prot, resp_ms;
  logic [3:0]         resp_idx;
  logic [39:0]        resp_addr;
`ifdef RAB_LOOKUP_STATS_EN
  logic               stat_clr;
  logic [31:0]        stat_hit, stat_miss, stat_multi, stat_prot;
`endif

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  rab_slice_lookup dut (
    .Clk_CI           (clk),
    .Rst_RBI          (rst_n),
    .CfgRegs_DI       (cfg_regs),
    .ReqValid_SI      (req_vld),
    .ReqReady_SO      (req_rdy),
    .ReqRw_DI         (req_rw),
    .ReqAddrMin_DI    (req_min),
    .ReqAddrMax_DI    (req_max),
    .ReqId_DI         (req_id),
    .RespValid_SO     (resp_vld),
    .RespReady_SI     (resp_rdy),
    .RespId_DO        (resp_id),
    .RespHit_SO       (resp_hit),
    .RespMulti_SO     (resp_multi),
    .RespProt_SO      (resp_prot),
    .RespIdx_DO       (resp_idx),
    .RespAddr_DO      (resp_addr),
    .RespMasterSel_SO (resp_ms)
`ifdef RAB_LOOKUP_STATS_EN
    ,
    .StatClr_SI       (stat_clr),
    .StatHit_DO       (stat_hit),
    .StatMiss_DO      (stat_miss),
    .StatMulti_DO     (stat_multi),
    .StatProt_DO      (stat_prot)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slice(input int i, input logic [63:0] mn, input logic [63:0] mx,
                           input logic [63:0] off, input logic [63:0] flags);
    cfg_regs[4*i+0] = mn;
    cfg_regs[4*i+1] = mx;
    cfg_regs[4*i+2] = off;
    cfg_regs[4*i+3] = flags;
  endtask

  // Single request with RespReady high; checks ready, latency and all fields.
  task automatic lookup(input string tag, input logic rw, input logic [31:0] mn, input logic [31:0] mx,
                        input logic [3:0] id, input logic ehit, input logic emulti, input logic eprot,
                        input logic [3:0] eidx, input logic [39:0] eaddr, input logic ems, input logic clr);
    @(negedge clk);
    req_vld = 1'b1; req_rw = rw; req_min = mn; req_max = mx; req_id = id; resp_rdy = 1'b1;
    #1 check({tag, ".req_rdy"}, 64'(req_rdy), 64'd1);
    @(posedge clk); #1 req_vld = 1'b0;
    @(negedge clk);
    check({tag, ".vld_n1"}, 64'(resp_vld), 64'd0);
    @(negedge clk);
    check({tag, ".vld_n2"}, 64'(resp_vld), 64'd1);
    check({tag, ".id"},     64'(resp_id), 64'(id));
    check({tag, ".hit"},    64'(resp_hit), 64'(ehit));
    check({tag, ".multi"},  64'(resp_multi), 64'(emulti));
    check({tag, ".prot"},   64'(resp_prot), 64'(eprot));
    check({tag, ".idx"},    64'(resp_idx), 64'(eidx));
    check({tag, ".addr"},   64'(resp_addr), 64'(eaddr));
    check({tag, ".ms"},     64'(resp_ms), 64'(ems));
`ifdef RAB_LOOKUP_STATS_EN
    stat_clr = clr;
`endif
    @(posedge clk); #1;
`ifdef RAB_LOOKUP_STATS_EN
    stat_clr = 1'b0;
`endif
    if (clr && 1'b0) $display("unreachable");
  endtask

  initial begin
    int  sent, rcvd;
    logic rr, acc, take;
    rst_n = 1'b0; cfg_regs = '0; req_vld = 1'b0; req_rw = 1'b0;
    req_min = '0; req_max = '0; req_id = '0; resp_rdy = 1'b0;
`ifdef RAB_LOOKUP_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst.vld",  64'(resp_vld), 64'd0);
    check("rst.hit",  64'(resp_hit), 64'd0);
    check("rst.addr", 64'(resp_addr), 64'd0);
    check("rst.id",   64'(resp_id), 64'd0);
    rst_n = 1'b1;
    #1 check("rst.req_rdy", 64'(req_rdy), 64'd1);

    // Basic read hit on slice 0
    set_slice(0, 64'h1000, 64'h1FFF, 64'h80_0000_0000, 64'h3);
    lookup("hit0", 1'b0, 32'h1200, 32'h123F, 4'd1, 1, 0, 0, 4'd0, 40'h80_0000_0200, 0, 0);
    lookup("prot", 1'b1, 32'h1200, 32'h123F, 4'd2, 0, 0, 1, 4'd0, 40'h0, 0, 0);
    lookup("miss", 1'b0, 32'h3000, 32'h3010, 4'd3, 0, 0, 0, 4'd0, 40'h0, 0, 0);

    set_slice(0, 64'h1000, 64'h1FFF, 64'h80_0000_0000, 64'h0);
    set_slice(2, 64'h4000, 64'h4FFF, 64'h10_0000_0000, 64'h7);
    set_slice(5, 64'h4000, 64'h4FFF, 64'h20_0000_0000, 64'hF);
    lookup("multi2", 1'b0, 32'h4100, 32'h4200, 4'd4, 0, 1, 0, 4'd2, 40'h0, 0, 0);
    set_slice(9, 64'h4000, 64'h4FFF, 64'h30_0000_0000, 64'h7);
    lookup("multi3", 1'b0, 32'h4100, 32'h4200, 4'd5, 0, 1, 0, 4'd2, 40'h0, 0, 0);

    set_slice(2, 64'h4000, 64'h4FFF, 64'h10_0000_0000, 64'h0);
    set_slice(5, 64'h4000, 64'h4FFF, 64'h20_0000_0000, 64'h0);
    set_slice(9, 64'h4000, 64'h4FFF, 64'h30_0000_0000, 64'h0);
    set_slice(0, 64'h1000, 64'h1FFF, 64'h80_0000_0000, 64'h3);
    lookup("straddle", 1'b0, 32'h1FF0, 32'h2010, 4'd6, 0, 0, 0, 4'd0, 40'h0, 0, 0);

    // Slice 1 matches without permission, slice 3 hits: hit wins, prot stays 0
    set_slice(1, 64'h10000, 64'h1FFFF, 64'h0, 64'h1);
    set_slice(3, 64'h10000, 64'h1FFFF, 64'hFF_FFFF_F000, 64'hF);
    lookup("wrap", 1'b1, 32'h12000, 32'h12003, 4'd7, 1, 0, 0, 4'd3, 40'h00_0000_1000, 1, 0);

    // Back-to-back with RespReady toggling every cycle
    sent = 0; rcvd = 0; rr = 1'b0;
    for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
      @(negedge clk);
      rr = ~rr; resp_rdy = rr;
      req_vld = (sent < 8); req_rw = 1'b0; req_id = 4'(sent);
      req_min = 32'h1000 + 32'(sent) * 32'h10; req_max = req_min + 32'hF;
      #1;
      acc  = req_vld && req_rdy;
      take = resp_vld && resp_rdy;
      if (take) begin
        check($sformatf("b2b%0d.id", rcvd), 64'(resp_id), 64'(rcvd));
        check($sformatf("b2b%0d.addr", rcvd), 64'(resp_addr), 64'h80_0000_0000 + 64'(rcvd) * 64'h10);
        rcvd++;
      end
      @(posedge clk);
      if (acc) sent++;
    end
    #1 req_vld = 1'b0; resp_rdy = 1'b1;
    check("b2b.count", 64'(rcvd), 64'd8);

    // Fill the pipe with RespReady low, then reset mid-stream
    @(negedge clk);
    resp_rdy = 1'b0; req_vld = 1'b1; req_rw = 1'b0; req_min = 32'h1000; req_max = 32'h1003; req_id = 4'hA;
    @(negedge clk); req_id = 4'hB;
    @(negedge clk); req_id = 4'hC;
    #1;
    check("full.req_rdy", 64'(req_rdy), 64'd0);
    check("full.vld",     64'(resp_vld), 64'd1);
    check("full.id",      64'(resp_id), 64'hA);
    @(negedge clk);
    check("stall.id",     64'(resp_id), 64'hA);
    check("stall.vld",    64'(resp_vld), 64'd1);
    rst_n = 1'b0; req_vld = 1'b0;
    #1;
    check("mrst.vld",  64'(resp_vld), 64'd0);
    check("mrst.id",   64'(resp_id), 64'd0);
    check("mrst.addr", 64'(resp_addr), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("mrst.req_rdy", 64'(req_rdy), 64'd1);
    lookup("postrst", 1'b0, 32'h1010, 32'h1013, 4'hD, 1, 0, 0, 4'd0, 40'h80_0000_0010, 0, 0);

`ifdef RAB_LOOKUP_STATS_EN
    @(negedge clk); stat_clr = 1'b1;
    @(posedge clk); #1 stat_clr = 1'b0;
    set_slice(2, 64'h4000, 64'h4FFF, 64'h10_0000_0000, 64'h7);
    set_slice(5, 64'h4000, 64'h4FFF, 64'h20_0000_0000, 64'hF);
    lookup("st.h1", 1'b0, 32'h1000, 32'h1003, 4'd1, 1, 0, 0, 4'd0, 40'h80_0000_0000, 0, 0);
    lookup("st.h2", 1'b0, 32'h1FFC, 32'h1FFF, 4'd2, 1, 0, 0, 4'd0, 40'h80_0000_0FFC, 0, 0);
    lookup("st.h3", 1'b0, 32'h1800, 32'h1800, 4'd3, 1, 0, 0, 4'd0, 40'h80_0000_0800, 0, 0);
    lookup("st.m",  1'b0, 32'h3000, 32'h3010, 4'd4, 0, 0, 0, 4'd0, 40'h0, 0, 0);
    lookup("st.p",  1'b1, 32'h1200, 32'h123F, 4'd5, 0, 0, 1, 4'd0, 40'h0, 0, 0);
    lookup("st.mu", 1'b0, 32'h4100, 32'h4200, 4'd6, 0, 1, 0, 4'd2, 40'h0, 0, 0);
    check("stat.hit",   64'(stat_hit),   64'd3);
    check("stat.miss",  64'(stat_miss),  64'd2);
    check("stat.multi", 64'(stat_multi), 64'd1);
    check("stat.prot",  64'(stat_prot),  64'd1);
    lookup("st.clr", 1'b0, 32'h1000, 32'h1003, 4'd7, 1, 0, 0, 4'd0, 40'h80_0000_0000, 0, 1);
    check("clr.hit",   64'(stat_hit),   64'd0);
    check("clr.miss",  64'(stat_miss),  64'd0);
    check("clr.multi", 64'(stat_multi), 64'd0);
    check("clr.prot",  64'(stat_prot),  64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
